// File: rtl/uart_traffic_ctrl.sv
// Purpose: drives the uart core TX/RX handshake in idle, pattern, echo and line-echo modes.
// Latency: every output is a flop; an RX byte sampled at edge N is acked/echoed during cycle N+1.
// Backpressure: TX waits for tx_free, and at most one TX and one RX strobe are issued every two cycles.
module uart_traffic_ctrl #(
  parameter int PERIOD_CYCLES = 4194304,
  parameter int CHAR_BASE     = 65,
  parameter int CHAR_COUNT    = 16,
  parameter int LINE_DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       tx_free,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       rx_available,
  input  logic [7:0] rx_data,
  output logic       rx_data_ack,
  output logic [7:0] drop_cnt,
  output logic       replaying
);

  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int IW = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1;
  localparam int AW = $clog2(LINE_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_REPLAY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [7:0]      line_buf [LINE_DEPTH];

  logic            tx_ok;
  logic            rx_ok;
  logic            send;
  logic [7:0]      send_dat;
  logic            ack;
  logic            drop;
  logic            wr_en;

  // The strobe registers double as the one-cycle cooldown after each pulse.
  assign tx_ok = tx_free & ~tx_data_valid;
  assign rx_ok = rx_available & ~rx_data_ack;

  assign replaying = (state_q == S_REPLAY);

  // Next-state and strobe decisions for the current mode / replay progress.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    send     = 1'b0;
    send_dat = tx_data;
    ack      = 1'b0;
    drop     = 1'b0;
    wr_en    = 1'b0;

    case (state_q)
      S_RUN: begin
        // A partial line is thrown away as soon as we are not collecting.
        if (mode != 2'd3) begin
          wr_ptr_d = '0;
        end
        case (mode)
          2'd1: begin
            if (cnt_q == CW'(PERIOD_CYCLES - 1)) begin
              cnt_d = '0;
              if (tx_ok) begin
                send     = 1'b1;
                send_dat = 8'(CHAR_BASE) + 8'(idx_q);
                idx_d    = (idx_q == IW'(CHAR_COUNT - 1)) ? '0 : idx_q + IW'(1);
              end else begin
                drop = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          2'd2: begin
            if (rx_ok) begin
              ack = 1'b1;
              if (tx_ok) begin
                send     = 1'b1;
                send_dat = rx_data;
              end else begin
                drop = 1'b1;
              end
            end
          end
          2'd3: begin
            if (rx_ok) begin
              ack      = 1'b1;
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              if (rx_data == 8'h0D || wr_ptr_q == AW'(LINE_DEPTH - 1)) begin
                state_d  = S_REPLAY;
                len_d    = {1'b0, wr_ptr_q} + LW'(1);
                rd_ptr_d = '0;
              end
            end
          end
          default: ;
        endcase
      end
      S_REPLAY: begin
        if (tx_ok) begin
          send     = 1'b1;
          send_dat = line_buf[rd_ptr_q];
          if ({1'b0, rd_ptr_q} == len_q - LW'(1)) begin
            state_d  = S_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      rx_data_ack   <= 1'b0;
      drop_cnt      <= 8'h00;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      len_q         <= len_d;
      tx_data       <= send_dat;
      tx_data_valid <= send;
      rx_data_ack   <= ack;
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Line buffer storage; contents are meaningless after reset so it has none.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[wr_ptr_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_traffic_ctrl.sv
module tb_uart_traffic_ctrl;

  localparam int P  = 8;
  localparam int CC = 3;
  localparam int LD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       tx_free = 1'b0;
  logic       rx_available = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       rx_data_ack;
  logic [7:0] drop_cnt;
  logic       replaying;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];

  typedef struct packed {
    logic [1:0] mode;
    logic       free;
    logic       av;
    logic [7:0] d;
    logic       vld;
    logic [7:0] txd;
    logic       ack;
    logic [7:0] drop;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  uart_traffic_ctrl #(
    .PERIOD_CYCLES(P),
    .CHAR_BASE(65),
    .CHAR_COUNT(CC),
    .LINE_DEPTH(LD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .tx_free(tx_free),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .rx_available(rx_available),
    .rx_data(rx_data),
    .rx_data_ack(rx_data_ack),
    .drop_cnt(drop_cnt),
    .replaying(replaying)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model RX FIFO: pop on a visible ack, then present the new head.
  task automatic fifo_update();
    if (rx_data_ack && q.size() > 0) void'(q.pop_front());
    rx_available = (q.size() != 0);
    rx_data      = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic idle_check(input string tag);
    int strobes;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_data_valid || rx_data_ack) strobes++;
    end
    chk({tag, "_no_strobes"}, strobes, 0);
  endtask

  task automatic echo_run(input logic free, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] drop_exp, input string tag);
    int         acks;
    int         b2b;
    logic       prev_v;
    logic       prev_a;
    logic [7:0] got[$];
    logic [7:0] exp_b[3];
    acks = 0; b2b = 0; prev_v = 1'b0; prev_a = 1'b0;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    q = {b0, b1, b2};
    mode = 2'd2;
    tx_free = free;
    fifo_update();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rx_data_ack) acks++;
      if (tx_data_valid) got.push_back(tx_data);
      if ((tx_data_valid && prev_v) || (rx_data_ack && prev_a)) b2b++;
      prev_v = tx_data_valid;
      prev_a = rx_data_ack;
      fifo_update();
    end
    mode = 2'd0;
    chk({tag, "_acks"}, acks, 3);
    chk({tag, "_sends"}, got.size(), free ? 3 : 0);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_b[i]);
    chk({tag, "_back_to_back"}, b2b, 0);
    chk({tag, "_drop"}, drop_cnt, drop_exp);
  endtask

  // Collect a line from q in mode 3 and follow its replay to the end.
  task automatic line_run(input int n, input logic to_idle, input string tag);
    int         acks;
    int         acks_at_rise;
    int         ack_in_rep;
    logic       seen_rise;
    logic       seen_fall;
    logic       prev_rep;
    logic [7:0] exp_b[$];
    logic [7:0] got[$];
    acks = 0; acks_at_rise = -1; ack_in_rep = 0;
    seen_rise = 1'b0; seen_fall = 1'b0; prev_rep = 1'b0;
    for (int i = 0; i < n; i++) exp_b.push_back(q[i]);
    mode = 2'd3;
    tx_free = 1'b1;
    fifo_update();
    for (int c = 0; c < 120 && !seen_fall; c++) begin
      tick();
      if (rx_data_ack) begin
        acks++;
        if (prev_rep) ack_in_rep++;
      end
      if (replaying && !prev_rep && !seen_rise) begin
        seen_rise = 1'b1;
        acks_at_rise = acks;
        if (to_idle) mode = 2'd0;
      end
      if (!replaying && prev_rep) seen_fall = 1'b1;
      if (tx_data_valid) got.push_back(tx_data);
      prev_rep = replaying;
      fifo_update();
    end
    chk({tag, "_replay_rise"}, seen_rise, 1'b1);
    chk({tag, "_acks_at_rise"}, acks_at_rise, n);
    chk({tag, "_replay_fall"}, seen_fall, 1'b1);
    chk({tag, "_sends"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_b[i]);
    chk({tag, "_ack_in_replay"}, ack_in_rep, 0);
  endtask

  initial begin
    // Echo vectors; starting point: tx_data=0x42, drop_cnt=1, no strobes pending.
    //            mode  free  av    d       vld   txd     ack   drop
    vecs[0] = '{2'd2, 1'b1, 1'b1, 8'h31, 1'b1, 8'h31, 1'b1, 8'd1};
    vecs[1] = '{2'd2, 1'b1, 1'b1, 8'h32, 1'b0, 8'h31, 1'b0, 8'd1};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 8'h32, 1'b1, 8'h32, 1'b1, 8'd1};
    vecs[3] = '{2'd2, 1'b1, 1'b0, 8'h00, 1'b0, 8'h32, 1'b0, 8'd1};
    vecs[4] = '{2'd2, 1'b0, 1'b1, 8'h33, 1'b0, 8'h32, 1'b1, 8'd2};
    vecs[5] = '{2'd2, 1'b1, 1'b1, 8'h34, 1'b0, 8'h32, 1'b0, 8'd2};
    vecs[6] = '{2'd2, 1'b1, 1'b1, 8'h34, 1'b1, 8'h34, 1'b1, 8'd2};
    vecs[7] = '{2'd2, 1'b1, 1'b1, 8'h35, 1'b0, 8'h34, 1'b0, 8'd2};
    vecs[8] = '{2'd0, 1'b1, 1'b1, 8'h35, 1'b0, 8'h34, 1'b0, 8'd2};
    vecs[9] = '{2'd0, 1'b1, 1'b1, 8'h35, 1'b0, 8'h34, 1'b0, 8'd2};

    // Reset state.
    tick(); tick(); tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_data_valid, 1'b0);
    chk("rst_ack", rx_data_ack, 1'b0);
    chk("rst_drop", drop_cnt, 8'h00);
    chk("rst_replaying", replaying, 1'b0);

    // Pattern: ticks every P cycles, characters A, B, C, A.
    mode = 2'd1;
    tx_free = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("pat_vld_e%0d", k), tx_data_valid, (k % P) == 0);
      if ((k % P) == 0)
        chk($sformatf("pat_dat_e%0d", k), tx_data, 8'h41 + 8'(((k / P) - 1) % CC));
    end
    chk("pat_drop", drop_cnt, 8'd0);

    // Busy TX across the tick at edge 40; edge 48 resends the skipped 'B'.
    tx_free = 1'b0;
    for (int k = 33; k <= 48; k++) begin
      tick();
      chk($sformatf("busy_vld_e%0d", k), tx_data_valid, k == 48);
      if (k == 40) begin
        chk("busy_drop", drop_cnt, 8'd1);
        tx_free = 1'b1;
      end
    end
    chk("busy_resend", tx_data, 8'h42);
    mode = 2'd0;
    idle_check("mode0");

    // Table-driven echo vectors.
    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].mode;
      tx_free = vecs[i].free;
      rx_available = vecs[i].av;
      rx_data = vecs[i].d;
      tick();
      chk($sformatf("vec%0d_vld", i), tx_data_valid, vecs[i].vld);
      chk($sformatf("vec%0d_txd", i), tx_data, vecs[i].txd);
      chk($sformatf("vec%0d_ack", i), rx_data_ack, vecs[i].ack);
      chk($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].drop);
    end
    rx_available = 1'b0;
    tick();

    // Echo against a FIFO model, free then busy.
    echo_run(1'b1, 8'h31, 8'h32, 8'h33, 8'd2, "echo_free");
    echo_run(1'b0, 8'h31, 8'h32, 8'h33, 8'd5, "echo_busy");
    tick();

    // Line echo terminated by CR.
    q = {8'h48, 8'h49, 8'h0D};
    line_run(3, 1'b0, "line_cr");
    mode = 2'd0;
    tick();

    // Full buffer without CR.
    q.delete();
    for (int i = 0; i < LD; i++) q.push_back(8'h60 + 8'(i));
    line_run(LD, 1'b0, "line_full");
    mode = 2'd0;
    tick();

    // Mode change during replay: replay completes, then silence.
    q = {8'h41, 8'h42, 8'h0D, 8'h5A};
    line_run(3, 1'b1, "line_to_idle");
    idle_check("after_replay");
    chk("after_replay_fifo_left", q.size(), 1);
    q.delete();
    rx_available = 1'b0;

    // Asynchronous reset in the middle of a replay.
    begin
      logic hit;
      hit = 1'b0;
      q = {8'h51, 8'h52, 8'h53, 8'h0D};
      mode = 2'd3;
      fifo_update();
      for (int c = 0; c < 40 && !hit; c++) begin
        tick();
        if (replaying && tx_data_valid) hit = 1'b1;
        fifo_update();
      end
      chk("midrst_reached_replay", hit, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_tx_valid", tx_data_valid, 1'b0);
      chk("midrst_ack", rx_data_ack, 1'b0);
      chk("midrst_drop", drop_cnt, 8'h00);
      chk("midrst_replaying", replaying, 1'b0);
      mode = 2'd0;
      q.delete();
      rx_available = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("postrst_replaying", replaying, 1'b0);
    end

    // Saturation: one drop every two cycles with TX permanently busy.
    mode = 2'd2;
    tx_free = 1'b0;
    rx_available = 1'b1;
    rx_data = 8'h55;
    for (int c = 0; c < 399; c++) tick();
    chk("sat_drop_200", drop_cnt, 8'd200);
    for (int c = 0; c < 221; c++) tick();
    chk("sat_drop_255", drop_cnt, 8'd255);
    chk("sat_no_send", tx_data_valid, 1'b0);
    rx_available = 1'b0;
    mode = 2'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_traffic_ctrl.md
# uart_traffic_ctrl

Parametrised UART traffic controller sitting between the board-level top and the `uart` core. It drives the core's TX/RX handshake and supports four run-time modes: idle, periodic character pattern, byte echo, and line-buffered echo. A sticky drop counter flags lost traffic. It replaces the hard-coded send/echo logic in the board top.

## Interface
- `PERIOD_CYCLES`, default 4194304: clock cycles between pattern ticks (≥ 4).
- `CHAR_BASE`, default 65: first pattern character (`'A'`).
- `CHAR_COUNT`, default 16: pattern length; index wraps to 0 after `CHAR_COUNT-1` (≥ 1).
- `LINE_DEPTH`, default 16: line buffer depth in bytes (≥ 2, power of two).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 2: 0 idle, 1 pattern, 2 echo, 3 line echo.
- `tx_free` in 1: UART core can accept a byte.
- `tx_data` out 8: byte to transmit; meaningful only while `tx_data_valid` is high.
- `tx_data_valid` out 1: one-cycle send strobe.
- `rx_available` in 1: UART core RX FIFO is non-empty.
- `rx_data` in 8: head of the RX FIFO.
- `rx_data_ack` out 1: one-cycle pop strobe.
- `drop_cnt` out 8: saturating count of dropped bytes and skipped ticks.
- `replaying` out 1: high while the line buffer is being transmitted.

## Operation
- FSM states: `S_RUN` and `S_REPLAY`. Reset enters `S_RUN`.
- `mode` is sampled every cycle in `S_RUN`. It is ignored in `S_REPLAY`; a new mode takes effect on the first cycle back in `S_RUN`.
- **TX cooldown:**
  - After any `tx_data_valid` pulse, no new pulse is issued on the following cycle.
  - A pulse is issued only when `tx_free`=1.
- **RX cooldown:**
  - After any `rx_data_ack` pulse, no new ack is issued on the following cycle.
  - The core's flag lags the pop by one cycle, so an ack on back-to-back cycles would pop twice.
- **Mode 0:**
  - No strobes are issued.
  - The period counter and pattern index hold their values.
  - The RX FIFO is left untouched.
- **Mode 1:**
  - The period counter runs 0..`PERIOD_CYCLES-1` and wraps.
  - At the terminal count, if `tx_free`=1 and TX is not in cooldown, send `CHAR_BASE+idx` and increment `idx` modulo `CHAR_COUNT`.
  - Otherwise the tick is skipped, `idx` holds, and `drop_cnt` increments.
  - RX is not acked.
- **Mode 2:**
  - If `rx_available`=1 and RX is not in cooldown, ack.
  - In the same cycle, if TX is allowed, send `rx_data`. Otherwise the byte is dropped and `drop_cnt` increments.
- **Mode 3 (collect):**
  - If `rx_available`=1 and RX is not in cooldown, ack and write `rx_data` to `buf[wr_ptr]`, then increment `wr_ptr`.
  - If the byte is 0x0D, or the write fills the buffer (`LINE_DEPTH` bytes), go to `S_REPLAY` with `len` = bytes stored (CR included).
- **`S_REPLAY`:**
  - `rd_ptr` starts at 0. On each allowed TX cycle, send `buf[rd_ptr]` and increment `rd_ptr`.
  - After sending the byte at `len-1`: clear `wr_ptr` and `rd_ptr`, return to `S_RUN`.
  - No acks are issued during replay.
- Leaving mode 3 with a partial line discards it: `wr_ptr` is cleared on any mode change away from 3.
- `drop_cnt` saturates at 255 and is cleared only by `rst`.
- `replaying` = (state == `S_REPLAY`).

## Timing
- All outputs are registered. Reset values:
  - `tx_data`=0, `tx_data_valid`=0, `rx_data_ack`=0, `drop_cnt`=0, `replaying`=0.
  - Period counter, pattern index and pointers are cleared.
- Echo latency: `rx_available`/`rx_data` sampled at edge N gives `rx_data_ack` and `tx_data_valid` high during cycle N+1. `tx_data` equals the sampled `rx_data`.
- Pattern: the first tick after reset fires `PERIOD_CYCLES` cycles after `rst` deasserts in mode 1.
- Maximum strobe rate is one per 2 cycles on each of TX and RX.
- `tx_data` holds its last value when `tx_data_valid`=0.
- Reset asserted mid-replay aborts the replay immediately. Buffer contents are don't-care after reset.
- Simultaneous pattern tick and mode change: the tick is evaluated under the old mode.

## Test plan
- **Pattern:** `PERIOD_CYCLES`=8, `CHAR_COUNT`=3, mode 1, `tx_free`=1 → strobes every 8 cycles carrying 0x41, 0x42, 0x43, 0x41…; `drop_cnt`=0.
- **Pattern with busy TX:** `tx_free`=0 across one tick → no strobe, `drop_cnt`=1; the next tick sends the same character that was skipped.
- **Echo:** mode 2, model FIFO holding 0x31, 0x32, 0x33, `tx_free`=1 → three acks and three sends of 0x31/0x32/0x33, never on consecutive cycles. Repeat with `tx_free`=0 → three acks, `drop_cnt`=3.
- **Line echo:** mode 3, feed "HI\r" → 3 acks, `replaying` rises, TX sends 0x48, 0x49, 0x0D, then `replaying` falls. Feed 16 bytes without CR → replay of all 16 starts after the 16th ack.
- **Mode change during replay:** switch to mode 0 during replay → replay completes, then no further strobes are issued.
- **Reset mid-operation:** pulse `rst` asynchronously during replay → all outputs are 0 in the same cycle and the FSM is in `S_RUN`. Saturation: force 300 drops → `drop_cnt`=255.
